// File: rtl/control_bus_rtc.sv
// Sequencer for the 8-bit multiplexed address/data bus of the external RTC.
// Latency: a transaction spans 2*(T_PULSO+T_ESPERA)+1 cycles after inicio is sampled; listo pulses in the last one.
// Backpressure: inicio is accepted only in IDLE or FIN; requests while busy are dropped, not queued.
//
// Ports:
//   clk, reset          clock and asynchronous active-high reset
//   inicio, escritura   transaction request and direction (1 = write), captured together
//   direccion_in/dato_in  address and write data, captured with inicio
//   bus_in              read data from the bus pads
//   direccion/dato      captured address/data feeding the pad mux; seleccion picks dato when 1
//   bus_oe              pad drive enable
//   cs_n/ad_n/rd_n/wr_n active-low RTC strobes
//   dato_leido          last captured read data
//   ocupado/listo       busy flag and one-cycle completion pulse
module control_bus_rtc #(
  parameter int T_PULSO  = 4,
  parameter int T_ESPERA = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inicio,
  input  logic       escritura,
  input  logic [7:0] direccion_in,
  input  logic [7:0] dato_in,
  input  logic [7:0] bus_in,
  output logic [7:0] direccion,
  output logic [7:0] dato,
  output logic       seleccion,
  output logic       bus_oe,
  output logic       cs_n,
  output logic       ad_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic [7:0] dato_leido,
  output logic       ocupado,
  output logic       listo
);

  typedef enum logic [2:0] {
    IDLE,
    DIR_PULSO,
    DIR_ESPERA,
    DATO_PULSO,
    DATO_ESPERA,
    FIN
  } state_t;

  localparam logic [7:0] ULT_PULSO  = 8'(T_PULSO - 1);
  localparam logic [7:0] ULT_ESPERA = 8'(T_ESPERA - 1);

  state_t     state, state_d;
  logic [7:0] cnt, cnt_d;
  logic       esc_q, esc_d;
  logic       captura;
  logic       lectura;
  logic       cs_d, ad_d, rd_d, wr_d, oe_d, sel_d;

  // Next state, plus the output values that belong to that next state, so
  // every output can be registered and still line up with its state.
  always_comb begin
    state_d = state;
    cnt_d   = cnt + 8'd1;
    captura = 1'b0;
    lectura = 1'b0;
    case (state)
      IDLE: begin
        cnt_d = 8'd0;
        if (inicio) begin
          state_d = DIR_PULSO;
          captura = 1'b1;
        end
      end
      DIR_PULSO: begin
        if (cnt == ULT_PULSO) begin
          state_d = DIR_ESPERA;
          cnt_d   = 8'd0;
        end
      end
      DIR_ESPERA: begin
        if (cnt == ULT_ESPERA) begin
          state_d = DATO_PULSO;
          cnt_d   = 8'd0;
        end
      end
      DATO_PULSO: begin
        if (cnt == ULT_PULSO) begin
          state_d = DATO_ESPERA;
          cnt_d   = 8'd0;
          // Read data is sampled at the edge that ends the read strobe.
          lectura = ~esc_q;
        end
      end
      DATO_ESPERA: begin
        if (cnt == ULT_ESPERA) begin
          state_d = FIN;
          cnt_d   = 8'd0;
        end
      end
      FIN: begin
        cnt_d   = 8'd0;
        state_d = IDLE;
        // A held inicio chains straight into the next transaction.
        if (inicio) begin
          state_d = DIR_PULSO;
          captura = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase

    esc_d = captura ? escritura : esc_q;

    cs_d  = 1'b1;
    ad_d  = 1'b1;
    rd_d  = 1'b1;
    wr_d  = 1'b1;
    oe_d  = 1'b0;
    sel_d = 1'b0;
    case (state_d)
      DIR_PULSO: begin
        // Address latch uses the write strobe for reads and writes alike.
        cs_d = 1'b0;
        ad_d = 1'b0;
        wr_d = 1'b0;
        oe_d = 1'b1;
      end
      DIR_ESPERA: begin
        oe_d = 1'b1;
      end
      DATO_PULSO: begin
        cs_d = 1'b0;
        if (esc_d) begin
          wr_d  = 1'b0;
          oe_d  = 1'b1;
          sel_d = 1'b1;
        end else begin
          rd_d = 1'b0;
        end
      end
      DATO_ESPERA: begin
        oe_d  = esc_d;
        sel_d = esc_d;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 8'd0;
      esc_q <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      esc_q <= esc_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cs_n       <= 1'b1;
      ad_n       <= 1'b1;
      rd_n       <= 1'b1;
      wr_n       <= 1'b1;
      bus_oe     <= 1'b0;
      seleccion  <= 1'b0;
      ocupado    <= 1'b0;
      listo      <= 1'b0;
      direccion  <= 8'd0;
      dato       <= 8'd0;
      dato_leido <= 8'd0;
    end else begin
      cs_n      <= cs_d;
      ad_n      <= ad_d;
      rd_n      <= rd_d;
      wr_n      <= wr_d;
      bus_oe    <= oe_d;
      seleccion <= sel_d;
      ocupado   <= (state_d != IDLE);
      listo     <= (state_d == FIN);
      if (captura) begin
        direccion <= direccion_in;
        dato      <= dato_in;
      end
      if (lectura) begin
        dato_leido <= bus_in;
      end
    end
  end

endmodule

// File: tb/tb_control_bus_rtc.sv
// Bench for control_bus_rtc: random and directed transactions against an RTC bus model.
// Expected waveforms come from each transaction's cycle offset; read data from a reference register map.
// Completion (listo) is checked by a monitor popping a scoreboard filled at acceptance time.
module tb_control_bus_rtc;
  localparam int TP   = 4;
  localparam int TE   = 2;
  localparam int LAST = 2 * (TP + TE) + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       inicio = 1'b0;
  logic       escritura = 1'b0;
  logic [7:0] direccion_in = 8'd0;
  logic [7:0] dato_in = 8'd0;
  logic [7:0] bus_in;
  logic [7:0] direccion, dato, dato_leido;
  logic       seleccion, bus_oe, cs_n, ad_n, rd_n, wr_n, ocupado, listo;

  control_bus_rtc #(.T_PULSO(TP), .T_ESPERA(TE)) dut (
    .clk(clk), .reset(rst), .inicio(inicio), .escritura(escritura),
    .direccion_in(direccion_in), .dato_in(dato_in), .bus_in(bus_in),
    .direccion(direccion), .dato(dato), .seleccion(seleccion), .bus_oe(bus_oe),
    .cs_n(cs_n), .ad_n(ad_n), .rd_n(rd_n), .wr_n(wr_n),
    .dato_leido(dato_leido), .ocupado(ocupado), .listo(listo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       esc;
    logic [7:0] dir;
    logic [7:0] dat;
    logic [7:0] rd_exp;
  } txn_t;

  txn_t       sb_q[$];
  txn_t       cur;
  int         k = 0;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] ref_mem[256];
  logic [7:0] dev_mem[256];
  logic [7:0] last_rd = 8'd0;
  logic [7:0] dev_addr = 8'd0;
  logic [7:0] junk = 8'd0;

  // RTC pads: drives its register while rd_n is low, noise otherwise.
  assign bus_in = rd_n ? junk : dev_mem[dev_addr];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  // {cs_n, ad_n, rd_n, wr_n, bus_oe, seleccion, ocupado, listo} at offset kk of a transaction.
  function automatic logic [7:0] exp_vec(input int kk, input logic esc);
    if (kk == 0)             return 8'b1111_0000;
    if (kk <= TP)            return 8'b0010_1010;
    if (kk <= TP + TE)       return 8'b1111_1010;
    if (kk <= 2 * TP + TE)   return esc ? 8'b0110_1110 : 8'b0101_0010;
    if (kk <= 2 * (TP + TE)) return esc ? 8'b1111_1110 : 8'b1111_0010;
    return 8'b1111_0011;
  endfunction

  // Reference model: cycle offset into the current transaction plus register map.
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      k = 0;
      sb_q.delete();
      last_rd = 8'd0;
    end else if ((k == 0 || k == LAST) && inicio) begin
      cur.esc = escritura;
      cur.dir = direccion_in;
      cur.dat = dato_in;
      if (escritura) begin
        ref_mem[direccion_in] = dato_in;
        cur.rd_exp = last_rd;
      end else begin
        cur.rd_exp = ref_mem[direccion_in];
      end
      last_rd = cur.rd_exp;
      sb_q.push_back(cur);
      k = 1;
    end else if (k == LAST) begin
      k = 0;
    end else if (k > 0) begin
      k++;
    end
  end

  // RTC device: latches the address on ad_n rising, stores data on wr_n rising in the data phase.
  initial begin
    logic p_ad, p_wr;
    logic [7:0] p_bus;
    p_ad = 1'b1;
    p_wr = 1'b1;
    p_bus = 8'd0;
    forever begin
      @(negedge clk);
      if (!p_ad && ad_n) dev_addr = p_bus;
      if (!p_wr && wr_n && p_ad && ad_n) dev_mem[dev_addr] = p_bus;
      p_ad  = ad_n;
      p_wr  = wr_n;
      p_bus = seleccion ? dato : direccion;
      junk  = 8'($urandom);
    end
  end

  // Monitor: per-cycle waveform check, scoreboard pop on every listo.
  initial forever begin
    txn_t t;
    @(negedge clk);
    if (!rst) begin
      chk("strobes", {24'd0, cs_n, ad_n, rd_n, wr_n, bus_oe, seleccion, ocupado, listo},
          {24'd0, exp_vec(k, cur.esc)});
      if (k > 0) begin
        chk("direccion", {24'd0, direccion}, {24'd0, cur.dir});
        chk("dato", {24'd0, dato}, {24'd0, cur.dat});
      end
      if (listo) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL listo_unexpected got=1 exp=0 at %0t", $time);
        end else begin
          t = sb_q.pop_front();
          chk("dato_leido", {24'd0, dato_leido}, {24'd0, t.rd_exp});
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (k != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (k != 0) begin
      checks++;
      errors++;
      $display("FAIL wait_idle_timeout got=%0d exp=0", k);
    end
  endtask

  task automatic start(input logic esc, input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    inicio = 1'b1;
    escritura = esc;
    direccion_in = a;
    dato_in = d;
  endtask

  task automatic scramble();
    inicio = 1'b0;
    escritura = 1'($urandom);
    direccion_in = 8'($urandom);
    dato_in = 8'($urandom);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = 8'($urandom);
      dev_mem[i] = ref_mem[i];
    end
    ref_mem[8'h22] = 8'hA5;
    dev_mem[8'h22] = 8'hA5;

    repeat (3) @(negedge clk);
    chk("rst_dato_leido", {24'd0, dato_leido}, 32'd0);
    chk("rst_direccion", {16'd0, direccion, dato}, 32'd0);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // Write 0x59 to 0x21; inputs change right after capture.
    start(1'b1, 8'h21, 8'h59);
    @(negedge clk);
    scramble();
    wait_idle();

    // Read 0x22, expect 0xA5 captured by the start of DATO_ESPERA.
    start(1'b0, 8'h22, 8'h00);
    @(negedge clk);
    scramble();
    repeat (10) @(negedge clk);
    chk("read_cycle11", {24'd0, dato_leido}, 32'h0000_00A5);
    wait_idle();

    // inicio pulsed in cycle 5 of a write is ignored.
    start(1'b1, 8'h30, 8'h3C);
    @(negedge clk);
    inicio = 1'b0;
    repeat (4) @(negedge clk);
    inicio = 1'b1;
    escritura = 1'b0;
    @(negedge clk);
    inicio = 1'b0;
    wait_idle();
    repeat (2) @(negedge clk);

    // inicio held across FIN: back-to-back transactions.
    start(1'b1, 8'h40, 8'h77);
    repeat (14) @(negedge clk);
    inicio = 1'b0;
    wait_idle();
    repeat (2) @(negedge clk);

    // Reset during the write data strobe releases the bus at once.
    start(1'b1, 8'h50, 8'h99);
    @(negedge clk);
    inicio = 1'b0;
    repeat (7) @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("async_rst", {27'd0, cs_n, ad_n, rd_n, wr_n, bus_oe}, {27'd0, 5'b11110});
    chk("async_rst_flags", {30'd0, ocupado, listo}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Random traffic over a small address window so reads hit earlier writes.
    repeat (900) begin
      @(negedge clk);
      inicio = ($urandom_range(0, 3) == 0);
      escritura = 1'($urandom);
      direccion_in = 8'($urandom_range(0, 15));
      dato_in = 8'($urandom);
    end
    @(negedge clk);
    inicio = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);
    chk("sb_empty", sb_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
